// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer.
//
// Contents:
//   timer_state_t : control states of the countdown FSM.
//   DEFAULT_*     : default geometry, a 4-digit decimal timer.
//   COUNT_W       : packed count width for the default geometry.
//   clamp_digit   : limits a raw preset digit to the largest legal digit.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    localparam int DEFAULT_NUM_DIGITS = 4;
    localparam int DEFAULT_RADIX      = 10;
    localparam int DEFAULT_DIGIT_W    = 4;
    localparam int COUNT_W            = DEFAULT_NUM_DIGITS * DEFAULT_DIGIT_W;

    // A digit that cannot exist in the chosen radix saturates to radix-1,
    // so 0xF loaded into a decimal timer reads back as 9.
    function automatic int unsigned clamp_digit(input int unsigned value,
                                                input int unsigned radix);
        return (value >= radix) ? radix - 1 : value;
    endfunction

endpackage

// File: rtl/timer_digit_cell.sv
// One digit of the countdown chain.
//
// Holds a single radix-RADIX digit and its registered "is zero" flag.
// A step decrements the digit only when every lower digit was zero
// (borrow_in high); a zero digit that decrements wraps to RADIX-1.
//
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset, digit clears to 0
//   load       : replace the digit with load_digit (wins over dec)
//   load_digit : value to load, already clamped to the radix
//   dec        : count step for the whole chain this cycle
//   borrow_in  : all lower digits are zero (tied high for digit 0)
//   digit      : current digit value
//   is_zero    : registered flag, digit == 0
//   borrow_out : borrow_in passed upward when this digit is zero
module timer_digit_cell #(
    parameter int RADIX   = 10,
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               dec,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_zero,
    output logic               borrow_out
);

    localparam logic [DIGIT_W-1:0] MAX_DIGIT = DIGIT_W'(RADIX - 1);

    logic [DIGIT_W-1:0] digit_next;

    always_comb begin
        digit_next = digit;
        if (load) begin
            digit_next = load_digit;
        end else if (dec && borrow_in) begin
            digit_next = is_zero ? MAX_DIGIT : digit - 1'b1;
        end
    end

    // The zero flag is computed from the next value so it is registered
    // together with the digit and never lags it by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit   <= '0;
            is_zero <= 1'b1;
        end else begin
            digit   <= digit_next;
            is_zero <= (digit_next == '0);
        end
    end

    assign borrow_out = is_zero & borrow_in;

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit countdown timer driven by the rising edges of a slow tick.
//
// A chain of NUM_DIGITS radix-RADIX digit cells counts down by one on each
// qualified tick edge; borrows ripple through the chain in the same cycle.
// Reaching zero raises a one-cycle expired pulse.
//
// Build option:
//   TIMER_AUTO_RELOAD_EN : when defined, the step that would reach zero
//                          reloads the last preset instead, pulses expired
//                          and keeps running, giving a periodic pulse.
//
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   reconfig   : load the (clamped) preset; highest priority below reset
//   load_val   : preset digits, digit i at [i*DIGIT_W +: DIGIT_W]
//   enable     : run permission, low pauses the count
//   tick       : time-base level, only rising edges count
//   digits     : current count, packed like load_val
//   digit_zero : per-digit "digit == 0" flags
//   zero       : whole count is zero
//   busy       : timer is in the RUN state
//   expired    : one-cycle pulse after the count reaches zero
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
    parameter int RADIX      = DEFAULT_RADIX,
    parameter int DIGIT_W    = DEFAULT_DIGIT_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          reconfig,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    input  logic                          enable,
    input  logic                          tick,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic [NUM_DIGITS-1:0]         digit_zero,
    output logic                          zero,
    output logic                          busy,
    output logic                          expired
);

    localparam int CNT_W = NUM_DIGITS * DIGIT_W;

    timer_state_t     state;
    timer_state_t     state_next;
    logic             tick_prev;
    logic             step;
    logic             cell_load;
    logic             dec;
    logic             expired_next;
    logic             count_is_one;
    logic             load_is_zero;
    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] load_bus;
    logic [NUM_DIGITS:0] borrow;

`ifdef TIMER_AUTO_RELOAD_EN
    logic [CNT_W-1:0] preset;
`endif

    // Saturate every preset digit to the radix before it reaches the cells.
    always_comb begin
        clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            clamped[i*DIGIT_W +: DIGIT_W] =
                DIGIT_W'(clamp_digit(32'(load_val[i*DIGIT_W +: DIGIT_W]), RADIX));
        end
    end

    assign load_is_zero = (clamped == '0);

    // Count of exactly one: digit 0 reads 1 and every higher digit is zero.
    always_comb begin
        count_is_one = (digits[DIGIT_W-1:0] == DIGIT_W'(1));
        for (int i = 1; i < NUM_DIGITS; i++) begin
            count_is_one = count_is_one & digit_zero[i];
        end
    end

    // Only a fresh rising edge in RUN with permission counts; a load in the
    // same cycle consumes the edge.
    assign step = tick & ~tick_prev & (state == RUN) & enable & ~reconfig;
    assign busy = (state == RUN);

    always_comb begin
        state_next   = state;
        cell_load    = 1'b0;
        load_bus     = clamped;
        dec          = 1'b0;
        expired_next = 1'b0;
        if (reconfig) begin
            cell_load = 1'b1;
            if (load_is_zero) begin
                state_next = IDLE;
            end else if (enable) begin
                state_next = RUN;
            end else begin
                state_next = PAUSE;
            end
        end else begin
            case (state)
                RUN: begin
                    if (!enable) begin
                        state_next = PAUSE;
                    end else if (step) begin
                        if (count_is_one) begin
                            expired_next = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                            cell_load = 1'b1;
                            load_bus  = preset;
`else
                            // Decrementing 1 lands on 0 through the normal
                            // ripple, so no explicit clear is needed.
                            dec        = 1'b1;
                            state_next = DONE;
`endif
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    if (enable) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_prev <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            tick_prev <= tick;
            expired   <= expired_next;
        end
    end

`ifdef TIMER_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            preset <= '0;
        end else if (reconfig) begin
            preset <= clamped;
        end
    end
`endif

    // borrow[i] is high when every digit below i is zero; the carry out of
    // the top cell is therefore the whole-count zero flag.
    assign borrow[0] = 1'b1;
    assign zero      = borrow[NUM_DIGITS];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        timer_digit_cell #(
            .RADIX   (RADIX),
            .DIGIT_W (DIGIT_W)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .load       (cell_load),
            .load_digit (load_bus[i*DIGIT_W +: DIGIT_W]),
            .dec        (dec),
            .borrow_in  (borrow[i]),
            .digit      (digits[i*DIGIT_W +: DIGIT_W]),
            .is_zero    (digit_zero[i]),
            .borrow_out (borrow[i+1])
        );
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Testbench for bcd_countdown_timer: directed scenarios plus randomized
// traffic, with a value-level reference model feeding a scoreboard queue.
module tb_bcd_countdown_timer;
    import timer_pkg::*;

    localparam int ND  = DEFAULT_NUM_DIGITS;
    localparam int RAD = DEFAULT_RADIX;
    localparam int DW  = DEFAULT_DIGIT_W;
    localparam int CW  = COUNT_W;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          reconfig;
    logic [CW-1:0] load_val;
    logic          enable;
    logic          tick;
    logic [CW-1:0] digits;
    logic [ND-1:0] digit_zero;
    logic          zero;
    logic          busy;
    logic          expired;

    bcd_countdown_timer #(
        .NUM_DIGITS (ND),
        .RADIX      (RAD),
        .DIGIT_W    (DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reconfig   (reconfig),
        .load_val   (load_val),
        .enable     (enable),
        .tick       (tick),
        .digits     (digits),
        .digit_zero (digit_zero),
        .zero       (zero),
        .busy       (busy),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] digits;
        logic [ND-1:0] dz;
        logic          zero;
        logic          busy;
        logic          expired;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state: the count as a plain integer.
    int m_cnt    = 0;
    int m_state  = M_IDLE;
    int m_preset = 0;
    bit m_tprev  = 1'b0;
    bit m_exp    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    function automatic int pow_r(input int e);
        int p = 1;
        for (int k = 0; k < e; k++) p = p * RAD;
        return p;
    endfunction

    function automatic int clamp_value(input logic [CW-1:0] lv);
        int v = 0;
        for (int i = 0; i < ND; i++) begin
            int d = int'(lv[i*DW +: DW]);
            if (d >= RAD) d = RAD - 1;
            v += d * pow_r(i);
        end
        return v;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        e.digits = '0;
        e.dz     = '0;
        for (int i = 0; i < ND; i++) begin
            int d = (m_cnt / pow_r(i)) % RAD;
            e.digits[i*DW +: DW] = DW'(d);
            e.dz[i] = (d == 0);
        end
        e.zero    = (m_cnt == 0);
        e.busy    = (m_state == M_RUN);
        e.expired = m_exp;
        return e;
    endfunction

    task automatic model_step(input bit r, input bit rc, input logic [CW-1:0] lv,
                              input bit en, input bit tk);
        bit step;
        bit nexp;
        if (!r) begin
            m_cnt = 0; m_state = M_IDLE; m_preset = 0; m_tprev = 1'b0; m_exp = 1'b0;
            return;
        end
        step = tk && !m_tprev && (m_state == M_RUN) && en && !rc;
        nexp = 1'b0;
        if (rc) begin
            m_cnt    = clamp_value(lv);
            m_preset = m_cnt;
            m_state  = (m_cnt == 0) ? M_IDLE : (en ? M_RUN : M_PAUSE);
        end else if (m_state == M_RUN) begin
            if (!en) m_state = M_PAUSE;
            else if (step) begin
                if (m_cnt == 1) begin
                    nexp = 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                    m_cnt = m_preset;
`else
                    m_cnt   = 0;
                    m_state = M_DONE;
`endif
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end else if (m_state == M_PAUSE) begin
            if (en) m_state = M_RUN;
        end
        m_tprev = tk;
        m_exp   = nexp;
    endtask

    // One clock: drive after the falling edge, model the rising edge, queue
    // the response the DUT must show afterwards.
    task automatic cycle(input bit r, input bit rc, input logic [CW-1:0] lv,
                         input bit en, input bit tk);
        @(negedge clk);
        #1;
        rst = r; reconfig = rc; load_val = lv; enable = en; tick = tk;
        @(posedge clk);
        #1;
        model_step(r, rc, lv, en, tk);
        sb.push_back(model_out());
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_digit_zero"}, 32'(digit_zero), 32'hF);
        check({tag, "_zero"}, 32'(zero), 32'h1);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_expired"}, 32'(expired), 32'h0);
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest
    // queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_digits", 32'(digits), 32'(e.digits));
                check("sb_digit_zero", 32'(digit_zero), 32'(e.dz));
                check("sb_zero", 32'(zero), 32'(e.zero));
                check("sb_busy", 32'(busy), 32'(e.busy));
                check("sb_expired", 32'(expired), 32'(e.expired));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; reconfig = 1'b0; load_val = '0; enable = 1'b0; tick = 1'b0;
        #1 rst = 1'b0;
        #1 check_reset_values("por");
        cycle(0, 0, '0, 0, 0);
        cycle(1, 0, '0, 0, 0);

        // Ripple borrow through two zero digits.
        cycle(1, 1, 16'h0100, 1, 0);
        check("ripple_load", 32'(digits), 32'h0100);
        cycle(1, 0, '0, 1, 1);
        check("ripple_digits", 32'(digits), 32'h0099);
        check("ripple_dz", 32'(digit_zero), 32'b1100);
        check("ripple_busy", 32'(busy), 32'h1);
        cycle(1, 0, '0, 1, 0);

        // Clamp with a simultaneous tick edge: load wins.
        cycle(1, 1, 16'h00FA, 1, 1);
        check("clamp_digits", 32'(digits), 32'h0099);
        cycle(1, 0, '0, 1, 0);
        check("clamp_no_dec", 32'(digits), 32'h0099);

        // Expiry from 3.
        cycle(1, 1, 16'h0003, 1, 0);
        for (int k = 1; k <= 3; k++) begin
            cycle(1, 0, '0, 1, 1);
`ifndef TIMER_AUTO_RELOAD_EN
            if (k == 3) begin
                check("expire_digits", 32'(digits), 32'h0);
                check("expire_zero", 32'(zero), 32'h1);
                check("expire_pulse", 32'(expired), 32'h1);
                check("expire_busy", 32'(busy), 32'h0);
            end else begin
                check("expire_early", 32'(expired), 32'h0);
            end
`endif
            cycle(1, 0, '0, 1, 0);
`ifndef TIMER_AUTO_RELOAD_EN
            if (k == 3) check("expire_one_cycle", 32'(expired), 32'h0);
`endif
        end
        cycle(1, 0, '0, 1, 1);
`ifndef TIMER_AUTO_RELOAD_EN
        check("done_ignores_tick", 32'(digits), 32'h0);
        check("done_no_pulse", 32'(expired), 32'h0);
`endif
        cycle(1, 0, '0, 1, 0);

        // Pause with tick held high: no decrement until a fresh edge.
        cycle(1, 1, 16'h0005, 1, 1);
        cycle(1, 0, '0, 0, 1);
        check("pause_busy", 32'(busy), 32'h0);
        check("pause_digits", 32'(digits), 32'h0005);
        cycle(1, 0, '0, 1, 1);
        check("resume_busy", 32'(busy), 32'h1);
        cycle(1, 0, '0, 1, 1);
        check("resume_no_dec", 32'(digits), 32'h0005);
        cycle(1, 0, '0, 1, 0);
        cycle(1, 0, '0, 1, 1);
        check("fresh_edge_dec", 32'(digits), 32'h0004);
        cycle(1, 0, '0, 1, 0);

        // Asynchronous reset mid-count.
        cycle(1, 1, 16'h0042, 1, 0);
        check("pre_reset_digits", 32'(digits), 32'h0042);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_values("async");
        cycle(0, 0, '0, 1, 0);
        cycle(1, 0, '0, 1, 1);
        check("idle_holds", 32'(digits), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        cycle(1, 0, '0, 1, 0);

`ifdef TIMER_AUTO_RELOAD_EN
        cycle(1, 1, 16'h0002, 1, 0);
        for (int j = 1; j <= 6; j++) begin
            cycle(1, 0, '0, 1, 1);
            check("reload_digits", 32'(digits), (j % 2 == 1) ? 32'h1 : 32'h2);
            check("reload_pulse", 32'(expired), (j % 2 == 0) ? 32'h1 : 32'h0);
            check("reload_busy", 32'(busy), 32'h1);
            cycle(1, 0, '0, 1, 0);
            check("reload_pulse_end", 32'(expired), 32'h0);
        end
`endif

        // Randomized traffic, small presets so expiry happens often.
        for (int i = 0; i < 1500; i++) begin
            bit            r;
            bit            rc;
            bit            en;
            bit            tk;
            logic [CW-1:0] lv;
            r  = ($urandom_range(0, 199) != 0);
            rc = ($urandom_range(0, 24) == 0);
            en = ($urandom_range(0, 7) != 0);
            tk = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) lv = CW'($urandom);
            else lv = CW'($urandom_range(0, 16'h0025));
            cycle(r, rc, lv, en, tk);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
